pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Hazard and control unit that drives the flush, hold and forwarding inputs of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the 5-stage CPU.
- Detects load-use hazards, EX-stage taken branches, ID-stage jumps and external interrupts.
- Sequences multi-cycle stalls and interrupt entry with a small state machine.
- Produces EX-stage forwarding selects.

Parameters:
- LU_STALL, 1, bubbles inserted per load-use hazard (1..7).
- IRQ_HOLDOFF, 4, cycles after an accepted interrupt during which IRQ is ignored (1..15).

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- ID_rs, ID_rt  in  5 each  source registers of the instruction in ID.
- ID_PCsrc  in  3  PC source of the instruction in ID: 0 = seq, 1 = branch, 2/3 = jump.
- EX_MemRd  in  1  instruction in EX is a load.
- EX_rt  in  5  load destination in EX.
- EX_rs_fw, EX_rt_fw  in  5 each  EX operand registers, used for forwarding.
- EX_BranchTaken  in  1  branch in EX resolved taken this cycle.
- MEM_RegWr  in  1  write-enable for the instruction in MEM.
- MEM_rdes  in  5  destination register for the instruction in MEM.
- WB_RegWr  in  1  write-enable for the instruction in WB.
- WB_rdes  in  5  destination register for the instruction in WB.
- IRQ  in  1  external interrupt request, level.
- PC_Hold  out  1  hold the PC.
- IF_Protect  out  1  hold IF/ID.
- IF_Flush  out  1  clear IF/ID.
- ID_Flush  out  1  clear ID/EX (bubble).
- ForwardA, ForwardB  out  2 each  0 = register file, 1 = MEM ALUOut, 2 = WB data.
- IntAccept  out  1  one-cycle pulse: interrupt taken, PC goes to the vector.
- branchBeforeInter  out  1  valid with IntAccept: ID holds a branch or jump, so ID/EX records PC-4.

Behaviour:
- Reset is synchronous and active-high; clock port is CLK, reset port is Reset.
- On Reset:
  - state = RUN, stall counter = 0, irq_pend = 0, holdoff counter = 0, irq_d = 0.
  - All control outputs are 0 in the same cycle Reset is sampled high.
  - Forward selects are combinational and unaffected by reset.
- States: RUN, STALL, INT.
- Load-use hazard (LU): EX_MemRd && EX_rt != 0 && (EX_rt == ID_rs || EX_rt == ID_rt).
- RUN, evaluated combinationally with priority high to low:
  1. EX_BranchTaken:
     - IF_Flush = 1 and ID_Flush = 1; PC_Hold = 0.
     - LU and jump are suppressed.
     - irq_pend is not accepted this cycle.
  2. LU:
     - PC_Hold = 1, IF_Protect = 1, ID_Flush = 1.
     - If LU_STALL > 1: next state = STALL and counter = LU_STALL-1.
  3. irq_pend && holdoff == 0:
     - IntAccept = 1 and IF_Flush = 1.
     - branchBeforeInter = (ID_PCsrc != 0).
     - Clear irq_pend; holdoff = IRQ_HOLDOFF; next state = INT.
  4. ID_PCsrc is 2 or 3 (jump): IF_Flush = 1.
- STALL:
  - PC_Hold = IF_Protect = ID_Flush = 1.
  - Counter decrements each cycle; return to RUN when counter reaches 1.
  - Total bubbles for one hazard = LU_STALL exactly.
  - An EX_BranchTaken cannot occur here, because EX holds a bubble.
- INT:
  - One cycle with ID_Flush = 1, discarding the instruction in ID.
  - Then unconditionally back to RUN.
- Interrupt latch:
  - irq_d <= IRQ every cycle.
  - irq_pend is set on a rising edge of IRQ (IRQ && !irq_d) only while holdoff == 0.
  - Holdoff decrements to 0, one step per cycle.
  - An edge arriving during STALL stays pending and is accepted in the first eligible RUN cycle.
- Forwarding (combinational, for each operand X in {rs, rt}):
  - Select 1 if MEM_RegWr && MEM_rdes != 0 && MEM_rdes == EX_X_fw.
  - Otherwise select 2 if WB_RegWr && WB_rdes != 0 && WB_rdes == EX_X_fw.
  - Otherwise select 0. MEM wins over WB.
- Register $0 never triggers a hazard or a forward.
- Reset asserted during STALL or INT returns to RUN next cycle with no residual flush, hold or pending interrupt.
- IF_Flush and IF_Protect are never both 1; when both conditions apply, Flush wins and Protect = 0.

Test Plan:
1. Load-use stall:
   - Stimulus: EX_MemRd = 1, EX_rt = 8, ID_rs = 8, LU_STALL = 1.
   - Required: one cycle of PC_Hold = IF_Protect = ID_Flush = 1, then all 0.
   - Repeat with LU_STALL = 3: exactly 3 cycles asserted.
2. Branch over load-use:
   - Stimulus: same cycle has EX_BranchTaken = 1 and the LU condition.
   - Required: IF_Flush = ID_Flush = 1, PC_Hold = 0, no STALL entry.
3. Forwarding:
   - Stimulus: MEM_rdes = WB_rdes = 5, both RegWr = 1, EX_rs_fw = 5.
   - Required: ForwardA = 1.
   - With MEM_RegWr = 0: ForwardA = 2.
   - With rdes = 0: ForwardA = 0.
4. Interrupt with branch in ID:
   - Stimulus: IRQ rises, ID_PCsrc = 1.
   - Required: next cycle IntAccept = 1, branchBeforeInter = 1, IF_Flush = 1; the following cycle ID_Flush = 1.
   - A second IRQ edge within 4 cycles is ignored; an edge at cycle 5 is accepted.
5. Interrupt during stall:
   - Stimulus: IRQ edge while in STALL with LU_STALL = 3.
   - Required: IntAccept in the first RUN cycle after the stall.
6. Reset mid-STALL:
   - Stimulus: Reset = 1 for one cycle.
   - Required: all outputs 0 the same cycle; the next non-hazard cycle has no hold or flush.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and control unit for the 5-stage pipeline.
// Drives flush/hold of the pipeline registers for load-use hazards, taken
// branches, jumps and interrupt entry, and computes EX-stage forwarding selects.
module pipe_hazard_ctrl #(
    parameter int unsigned LU_STALL    = 1,
    parameter int unsigned IRQ_HOLDOFF = 4
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic [2:0] ID_PCsrc,
    input  logic       EX_MemRd,
    input  logic [4:0] EX_rt,
    input  logic [4:0] EX_rs_fw,
    input  logic [4:0] EX_rt_fw,
    input  logic       EX_BranchTaken,
    input  logic       MEM_RegWr,
    input  logic [4:0] MEM_rdes,
    input  logic       WB_RegWr,
    input  logic [4:0] WB_rdes,
    input  logic       IRQ,
    output logic       PC_Hold,
    output logic       IF_Protect,
    output logic       IF_Flush,
    output logic       ID_Flush,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB,
    output logic       IntAccept,
    output logic       branchBeforeInter
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_INT   = 2'd2;

    localparam logic [2:0] STALL_RELOAD   = 3'(LU_STALL - 1);
    localparam logic [3:0] HOLDOFF_RELOAD = 4'(IRQ_HOLDOFF);
    localparam bit         MULTI_STALL    = (LU_STALL > 1);

    logic [1:0] state_q, state_d;
    logic [2:0] stall_cnt_q, stall_cnt_d;
    logic [3:0] holdoff_q, holdoff_d;
    logic       irq_pend_q, irq_pend_d;
    logic       irq_dly_q, irq_dly_d;

    logic       load_use;
    logic       id_is_jump;
    logic       irq_edge;
    logic       irq_ready;

    logic       pc_hold_c;
    logic       if_protect_c;
    logic       if_flush_c;
    logic       id_flush_c;
    logic       int_accept_c;
    logic       branch_before_int_c;

    // Hazard conditions derived from the current pipeline contents.
    always_comb begin
        load_use   = EX_MemRd && (EX_rt != 5'd0) &&
                     ((EX_rt == ID_rs) || (EX_rt == ID_rt));
        id_is_jump = (ID_PCsrc == 3'd2) || (ID_PCsrc == 3'd3);
        irq_edge   = IRQ && !irq_dly_q;
        irq_ready  = irq_pend_q && (holdoff_q == 4'd0);
    end

    // Next-state and control-output logic; reset forces every control output low.
    always_comb begin
        state_d             = state_q;
        stall_cnt_d         = stall_cnt_q;
        irq_pend_d          = irq_pend_q;
        irq_dly_d           = IRQ;
        holdoff_d           = (holdoff_q != 4'd0) ? (holdoff_q - 4'd1) : 4'd0;
        pc_hold_c           = 1'b0;
        if_protect_c        = 1'b0;
        if_flush_c          = 1'b0;
        id_flush_c          = 1'b0;
        int_accept_c        = 1'b0;
        branch_before_int_c = 1'b0;

        if (irq_edge && (holdoff_q == 4'd0)) begin
            irq_pend_d = 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                if (EX_BranchTaken) begin
                    if_flush_c = 1'b1;
                    id_flush_c = 1'b1;
                end else if (load_use) begin
                    pc_hold_c    = 1'b1;
                    if_protect_c = 1'b1;
                    id_flush_c   = 1'b1;
                    if (MULTI_STALL) begin
                        state_d     = ST_STALL;
                        stall_cnt_d = STALL_RELOAD;
                    end
                end else if (irq_ready) begin
                    int_accept_c        = 1'b1;
                    if_flush_c          = 1'b1;
                    branch_before_int_c = (ID_PCsrc != 3'd0);
                    irq_pend_d          = 1'b0;
                    holdoff_d           = HOLDOFF_RELOAD;
                    state_d             = ST_INT;
                end else if (id_is_jump) begin
                    if_flush_c = 1'b1;
                end
            end
            ST_STALL: begin
                pc_hold_c    = 1'b1;
                if_protect_c = 1'b1;
                id_flush_c   = 1'b1;
                if (stall_cnt_q <= 3'd1) begin
                    stall_cnt_d = 3'd0;
                    state_d     = ST_RUN;
                end else begin
                    stall_cnt_d = stall_cnt_q - 3'd1;
                end
            end
            ST_INT: begin
                id_flush_c = 1'b1;
                state_d    = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (Reset) begin
            state_d             = ST_RUN;
            stall_cnt_d         = 3'd0;
            irq_pend_d          = 1'b0;
            irq_dly_d           = 1'b0;
            holdoff_d           = 4'd0;
            pc_hold_c           = 1'b0;
            if_protect_c        = 1'b0;
            if_flush_c          = 1'b0;
            id_flush_c          = 1'b0;
            int_accept_c        = 1'b0;
            branch_before_int_c = 1'b0;
        end
    end

    // State, counters and interrupt latch registers.
    always_ff @(posedge CLK) begin
        state_q     <= state_d;
        stall_cnt_q <= stall_cnt_d;
        holdoff_q   <= holdoff_d;
        irq_pend_q  <= irq_pend_d;
        irq_dly_q   <= irq_dly_d;
    end

    // Forwarding selects: MEM result has priority over WB, $0 never forwards.
    always_comb begin
        ForwardA = 2'd0;
        ForwardB = 2'd0;
        if (MEM_RegWr && (MEM_rdes != 5'd0) && (MEM_rdes == EX_rs_fw)) begin
            ForwardA = 2'd1;
        end else if (WB_RegWr && (WB_rdes != 5'd0) && (WB_rdes == EX_rs_fw)) begin
            ForwardA = 2'd2;
        end
        if (MEM_RegWr && (MEM_rdes != 5'd0) && (MEM_rdes == EX_rt_fw)) begin
            ForwardB = 2'd1;
        end else if (WB_RegWr && (WB_rdes != 5'd0) && (WB_rdes == EX_rt_fw)) begin
            ForwardB = 2'd2;
        end
    end

    // Flush of IF/ID always overrides a request to protect it.
    always_comb begin
        PC_Hold           = pc_hold_c;
        IF_Flush          = if_flush_c;
        IF_Protect        = if_protect_c && !if_flush_c;
        ID_Flush          = id_flush_c;
        IntAccept         = int_accept_c;
        branchBeforeInter = branch_before_int_c;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl: one instance with single-bubble
// load-use stalls and one with three-bubble stalls share all inputs.
module tb_pipe_hazard_ctrl;

    logic       CLK;
    logic       Reset;
    logic [4:0] ID_rs, ID_rt;
    logic [2:0] ID_PCsrc;
    logic       EX_MemRd;
    logic [4:0] EX_rt, EX_rs_fw, EX_rt_fw;
    logic       EX_BranchTaken;
    logic       MEM_RegWr, WB_RegWr;
    logic [4:0] MEM_rdes, WB_rdes;
    logic       IRQ;

    logic       pc_hold_1, if_protect_1, if_flush_1, id_flush_1, int_accept_1, bbi_1;
    logic [1:0] fwd_a_1, fwd_b_1;
    logic       pc_hold_3, if_protect_3, if_flush_3, id_flush_3, int_accept_3, bbi_3;
    logic [1:0] fwd_a_3, fwd_b_3;

    int compared   = 0;
    int mismatched = 0;

    string      tag_q[$];
    logic [5:0] exp1_q[$];
    logic [5:0] exp3_q[$];
    logic [3:0] expf_q[$];

    pipe_hazard_ctrl #(.LU_STALL(1), .IRQ_HOLDOFF(4)) dut1 (
        .CLK(CLK), .Reset(Reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_PCsrc(ID_PCsrc),
        .EX_MemRd(EX_MemRd), .EX_rt(EX_rt), .EX_rs_fw(EX_rs_fw), .EX_rt_fw(EX_rt_fw),
        .EX_BranchTaken(EX_BranchTaken), .MEM_RegWr(MEM_RegWr), .MEM_rdes(MEM_rdes),
        .WB_RegWr(WB_RegWr), .WB_rdes(WB_rdes), .IRQ(IRQ),
        .PC_Hold(pc_hold_1), .IF_Protect(if_protect_1), .IF_Flush(if_flush_1),
        .ID_Flush(id_flush_1), .ForwardA(fwd_a_1), .ForwardB(fwd_b_1),
        .IntAccept(int_accept_1), .branchBeforeInter(bbi_1)
    );

    pipe_hazard_ctrl #(.LU_STALL(3), .IRQ_HOLDOFF(4)) dut3 (
        .CLK(CLK), .Reset(Reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_PCsrc(ID_PCsrc),
        .EX_MemRd(EX_MemRd), .EX_rt(EX_rt), .EX_rs_fw(EX_rs_fw), .EX_rt_fw(EX_rt_fw),
        .EX_BranchTaken(EX_BranchTaken), .MEM_RegWr(MEM_RegWr), .MEM_rdes(MEM_rdes),
        .WB_RegWr(WB_RegWr), .WB_rdes(WB_rdes), .IRQ(IRQ),
        .PC_Hold(pc_hold_3), .IF_Protect(if_protect_3), .IF_Flush(if_flush_3),
        .ID_Flush(id_flush_3), .ForwardA(fwd_a_3), .ForwardB(fwd_b_3),
        .IntAccept(int_accept_3), .branchBeforeInter(bbi_3)
    );

    // Free-running clock, period 10.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected control vectors: {PC_Hold, IF_Protect, IF_Flush, ID_Flush, IntAccept, branchBeforeInter}
    localparam logic [5:0] C_NONE   = 6'b000000;
    localparam logic [5:0] C_LU     = 6'b110100;
    localparam logic [5:0] C_BRANCH = 6'b001100;
    localparam logic [5:0] C_JUMP   = 6'b001000;
    localparam logic [5:0] C_INT    = 6'b000100;
    localparam logic [5:0] C_ACC    = 6'b001010;
    localparam logic [5:0] C_ACC_BR = 6'b001011;

    task automatic clearInputs();
        Reset          = 1'b0;
        ID_rs          = 5'd0;
        ID_rt          = 5'd0;
        ID_PCsrc       = 3'd0;
        EX_MemRd       = 1'b0;
        EX_rt          = 5'd0;
        EX_rs_fw       = 5'd0;
        EX_rt_fw       = 5'd0;
        EX_BranchTaken = 1'b0;
        MEM_RegWr      = 1'b0;
        MEM_rdes       = 5'd0;
        WB_RegWr       = 1'b0;
        WB_rdes        = 5'd0;
        IRQ            = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input logic [5:0] e1,
                                 input logic [5:0] e3, input logic [3:0] ef);
        tag_q.push_back(tag);
        exp1_q.push_back(e1);
        exp3_q.push_back(e3);
        expf_q.push_back(ef);
    endtask

    task automatic checkOutput();
        string      tag;
        logic [5:0] e1, e3, o1, o3;
        logic [3:0] ef, of;
        #1;
        while (tag_q.size() > 0) begin
            tag = tag_q.pop_front();
            e1  = exp1_q.pop_front();
            e3  = exp3_q.pop_front();
            ef  = expf_q.pop_front();
            o1  = {pc_hold_1, if_protect_1, if_flush_1, id_flush_1, int_accept_1, bbi_1};
            o3  = {pc_hold_3, if_protect_3, if_flush_3, id_flush_3, int_accept_3, bbi_3};
            of  = {fwd_a_1, fwd_b_1};
            compared++;
            assert (o1 === e1) else begin
                mismatched++;
                $error("[TB] FAIL %s ctrl(LU_STALL=1) observed=%b expected=%b", tag, o1, e1);
            end
            compared++;
            assert (o3 === e3) else begin
                mismatched++;
                $error("[TB] FAIL %s ctrl(LU_STALL=3) observed=%b expected=%b", tag, o3, e3);
            end
            compared++;
            assert (of === ef) else begin
                mismatched++;
                $error("[TB] FAIL %s fwd{A,B} observed=%b expected=%b", tag, of, ef);
            end
        end
    endtask

    // One clock cycle: record expectations, compare after settling, advance to next negedge.
    task automatic cycle(input string tag, input logic [5:0] e1,
                         input logic [5:0] e3, input logic [3:0] ef);
        applyStimulus(tag, e1, e3, ef);
        checkOutput();
        @(negedge CLK);
    endtask

    initial begin
        // Reset cycle: controls forced low, forwarding still live.
        clearInputs();
        Reset = 1'b1; EX_BranchTaken = 1'b1;
        MEM_RegWr = 1'b1; MEM_rdes = 5'd5; EX_rs_fw = 5'd5;
        cycle("reset", C_NONE, C_NONE, 4'b0100);

        // Load-use stall: one bubble vs three bubbles.
        clearInputs(); EX_MemRd = 1'b1; EX_rt = 5'd8; ID_rs = 5'd8;
        cycle("lu_start", C_LU, C_LU, 4'b0000);
        clearInputs();
        cycle("lu_b2", C_NONE, C_LU, 4'b0000);
        clearInputs();
        cycle("lu_b3", C_NONE, C_LU, 4'b0000);
        clearInputs();
        cycle("lu_done", C_NONE, C_NONE, 4'b0000);
        clearInputs(); EX_MemRd = 1'b1; EX_rt = 5'd0; ID_rs = 5'd0;
        cycle("lu_r0", C_NONE, C_NONE, 4'b0000);

        // Taken branch overrides load-use and jump.
        clearInputs(); EX_BranchTaken = 1'b1; EX_MemRd = 1'b1; EX_rt = 5'd8;
        ID_rt = 5'd8; ID_PCsrc = 3'd2;
        cycle("br_over_lu", C_BRANCH, C_BRANCH, 4'b0000);
        clearInputs();
        cycle("br_no_stall", C_NONE, C_NONE, 4'b0000);

        // Forwarding priority and $0 suppression.
        clearInputs(); MEM_RegWr = 1'b1; WB_RegWr = 1'b1; MEM_rdes = 5'd5;
        WB_rdes = 5'd5; EX_rs_fw = 5'd5; EX_rt_fw = 5'd5;
        cycle("fw_mem", C_NONE, C_NONE, 4'b0101);
        MEM_RegWr = 1'b0;
        cycle("fw_wb", C_NONE, C_NONE, 4'b1010);
        MEM_RegWr = 1'b1; MEM_rdes = 5'd0; WB_rdes = 5'd0; EX_rs_fw = 5'd0; EX_rt_fw = 5'd0;
        cycle("fw_r0", C_NONE, C_NONE, 4'b0000);
        MEM_rdes = 5'd3; WB_rdes = 5'd7; EX_rs_fw = 5'd7; EX_rt_fw = 5'd3;
        cycle("fw_mixed", C_NONE, C_NONE, 4'b1001);

        // Jump flush; load-use beats jump, and the held jump is flushed afterwards.
        clearInputs(); ID_PCsrc = 3'd3;
        cycle("jump", C_JUMP, C_JUMP, 4'b0000);
        clearInputs(); ID_PCsrc = 3'd2; EX_MemRd = 1'b1; EX_rt = 5'd9; ID_rt = 5'd9;
        cycle("lu_over_jump", C_LU, C_LU, 4'b0000);
        clearInputs(); ID_PCsrc = 3'd2;
        cycle("jump_stall_b2", C_JUMP, C_LU, 4'b0000);
        cycle("jump_stall_b3", C_JUMP, C_LU, 4'b0000);
        cycle("jump_after", C_JUMP, C_JUMP, 4'b0000);
        clearInputs();
        cycle("idle0", C_NONE, C_NONE, 4'b0000);

        // Interrupt with branch in ID, then holdoff window.
        clearInputs(); IRQ = 1'b1; ID_PCsrc = 3'd1;
        cycle("irq_edge", C_NONE, C_NONE, 4'b0000);
        cycle("irq_accept_br", C_ACC_BR, C_ACC_BR, 4'b0000);
        clearInputs();
        cycle("irq_int", C_INT, C_INT, 4'b0000);
        clearInputs(); IRQ = 1'b1;
        cycle("holdoff_edge", C_NONE, C_NONE, 4'b0000);
        clearInputs();
        cycle("holdoff_2", C_NONE, C_NONE, 4'b0000);
        cycle("holdoff_1", C_NONE, C_NONE, 4'b0000);
        IRQ = 1'b1;
        cycle("irq_edge5", C_NONE, C_NONE, 4'b0000);
        cycle("irq_accept5", C_ACC, C_ACC, 4'b0000);
        clearInputs();
        cycle("irq_int5", C_INT, C_INT, 4'b0000);
        cycle("idle1", C_NONE, C_NONE, 4'b0000);
        cycle("idle2", C_NONE, C_NONE, 4'b0000);
        cycle("idle3", C_NONE, C_NONE, 4'b0000);

        // Interrupt edge arriving during a three-bubble stall.
        clearInputs(); EX_MemRd = 1'b1; EX_rt = 5'd4; ID_rs = 5'd4;
        cycle("st_lu", C_LU, C_LU, 4'b0000);
        clearInputs(); IRQ = 1'b1;
        cycle("st_irq_edge", C_NONE, C_LU, 4'b0000);
        cycle("st_last", C_ACC, C_LU, 4'b0000);
        clearInputs();
        cycle("st_accept", C_INT, C_ACC, 4'b0000);
        cycle("st_int", C_NONE, C_INT, 4'b0000);
        cycle("st_idle", C_NONE, C_NONE, 4'b0000);

        // Reset in the middle of a stall.
        clearInputs(); EX_MemRd = 1'b1; EX_rt = 5'd6; ID_rt = 5'd6;
        cycle("rs_lu", C_LU, C_LU, 4'b0000);
        clearInputs(); Reset = 1'b1; EX_BranchTaken = 1'b1; ID_PCsrc = 3'd3;
        cycle("rs_reset", C_NONE, C_NONE, 4'b0000);
        clearInputs(); IRQ = 1'b1;
        cycle("rs_after", C_NONE, C_NONE, 4'b0000);
        cycle("rs_irq_accept", C_ACC, C_ACC, 4'b0000);
        clearInputs();
        cycle("rs_irq_int", C_INT, C_INT, 4'b0000);
        cycle("rs_idle", C_NONE, C_NONE, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
